// File: rtl/raven_bus_pkg.sv
// raven_bus_pkg: shared bus-cycle states, region encoding and default wait/timeout constants
package raven_bus_pkg;
  typedef enum logic [2:0] {SYNC, IDLE, WAIT, ACK, ERR} bus_state_t;
  typedef enum logic [1:0] {REG_NONE, REG_ROM, REG_RAM, REG_IO} region_t;
  localparam int WAIT_ROM_DEF     = 2;
  localparam int WAIT_RAM_DEF     = 0;
  localparam int WAIT_IO_DEF      = 4;
  localparam int BERR_TIMEOUT_DEF = 64;
  function automatic region_t decode_region(input logic rom, input logic ram, input logic io);
    return rom ? REG_ROM : ram ? REG_RAM : io ? REG_IO : REG_NONE;
  endfunction
endpackage

// File: rtl/cpu_clk_edge.sv
// cpu_clk_edge: one clk_in-cycle pulse on each rising edge of the sampled cpu_clk level
module cpu_clk_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic cpu_clk,
  output logic cpu_rise
);
  logic cpu_clk_q;
  always_ff @(posedge clk_in)
    if (reset) cpu_clk_q <= 1'b0;
    else cpu_clk_q <= cpu_clk;
  assign cpu_rise = cpu_clk & ~cpu_clk_q;
endmodule

// File: rtl/dtack_gen.sv
// dtack_gen: 68000 DTACK/BERR generator counting CPU-clock wait states per decoded region
module dtack_gen
  import raven_bus_pkg::*;
#(
  parameter int WAIT_ROM     = WAIT_ROM_DEF,
  parameter int WAIT_RAM     = WAIT_RAM_DEF,
  parameter int WAIT_IO      = WAIT_IO_DEF,
  parameter int BERR_TIMEOUT = BERR_TIMEOUT_DEF,
  parameter int CNT_W        = 8
) (
  input  logic clk_in,
  input  logic reset,
  input  logic cpu_clk,
  input  logic as_n,
  input  logic cs_rom,
  input  logic cs_ram,
  input  logic cs_io,
  input  logic io_rdy,
  output logic dtack_n,
  output logic berr_n,
  output logic busy
);
  localparam logic [CNT_W-1:0] T_ROM  = CNT_W'(WAIT_ROM);
  localparam logic [CNT_W-1:0] T_RAM  = CNT_W'(WAIT_RAM);
  localparam logic [CNT_W-1:0] T_IO   = CNT_W'(WAIT_IO);
  localparam logic [CNT_W-1:0] T_BERR = CNT_W'(BERR_TIMEOUT);
  localparam logic [CNT_W-1:0] MAX    = '1;
  bus_state_t state, next;
  region_t region, region_d;
  logic [CNT_W-1:0] target, target_d, wait_cnt, to_cnt;
  logic as_q, cpu_rise, ack_ok, zero_ok, timeout;
  cpu_clk_edge u_edge (.clk_in(clk_in), .reset(reset), .cpu_clk(cpu_clk), .cpu_rise(cpu_rise));
  always_comb begin
    region_d = decode_region(cs_rom, cs_ram, cs_io);
    target_d = region_d == REG_ROM ? T_ROM : region_d == REG_RAM ? T_RAM : region_d == REG_IO ? T_IO : '0;
    zero_ok  = target_d == '0 && region_d != REG_NONE && (region_d != REG_IO || io_rdy);
    ack_ok   = wait_cnt >= target && region != REG_NONE && (region != REG_IO || io_rdy);
    timeout  = to_cnt >= T_BERR;
    next     = state;
    case (state)
      SYNC:     next = as_q ? IDLE : SYNC;
      IDLE:     next = as_q ? IDLE : zero_ok ? ACK : WAIT;
      WAIT:     next = as_q ? IDLE : ack_ok ? ACK : timeout ? ERR : WAIT;
      ACK, ERR: next = as_q ? IDLE : state;
      default:  next = SYNC;
    endcase
  end
  assign busy = state == WAIT || state == ACK || state == ERR;
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= SYNC;
      as_q     <= 1'b0;
      region   <= REG_NONE;
      target   <= '0;
      wait_cnt <= '0;
      to_cnt   <= '0;
      dtack_n  <= 1'b1;
      berr_n   <= 1'b1;
    end else begin
      as_q    <= as_n;
      state   <= next;
      // outputs release on the same edge that first sees as_q high
      dtack_n <= !(state == ACK && !as_q);
      berr_n  <= !(state == ERR && !as_q);
      if (state == IDLE && !as_q) begin
        region   <= region_d;
        target   <= target_d;
        wait_cnt <= '0;
        to_cnt   <= '0;
      end else if (state == WAIT && cpu_rise) begin
        wait_cnt <= wait_cnt == MAX ? wait_cnt : wait_cnt + 1'b1;
        to_cnt   <= to_cnt == MAX ? to_cnt : to_cnt + 1'b1;
      end
    end
  end
endmodule
